// File: rtl/comb_tdm.sv
// Time-division-multiplexed CIC comb: M cascaded differentiators y = x - x[-N],
// with an independent delay history per channel sharing one arithmetic path.
module comb_tdm #(
  parameter int unsigned M    = 1,
  parameter int unsigned N    = 2,
  parameter int unsigned BITS = 10,
  parameter int unsigned CH   = 4,
  parameter int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] stream_in,
  input  logic [CHW-1:0]         chan_in,
  input  logic                   valid,
  input  logic                   bypass,
  input  logic                   clear,
  output logic signed [BITS-1:0] stream_out,
  output logic [CHW-1:0]         chan_out,
  output logic                   ready
);

  // History is sized to the full tag range so any tag value indexes in bounds.
  localparam int unsigned CH_SLOTS = 1 << CHW;

  logic [BITS-1:0] hist_q [M][CH_SLOTS][N];
  logic [BITS-1:0] data_q [M];
  logic [CHW-1:0]  chan_q [M];
  logic            byp_q  [M];
  logic            vld_q  [M];

  logic [BITS-1:0] stg_x [M];
  logic [CHW-1:0]  stg_c [M];
  logic            stg_b [M];
  logic            stg_v [M];
  logic            chan_ok;

  // Stage inputs: stage 0 from the ports, later stages from the previous register.
  always_comb begin
    chan_ok = (32'(chan_in) < CH);
    for (int s = 0; s < int'(M); s++) begin
      if (s == 0) begin
        stg_x[s] = stream_in;
        stg_c[s] = chan_in;
        stg_b[s] = bypass;
        stg_v[s] = valid && chan_ok;
      end else begin
        stg_x[s] = data_q[s-1];
        stg_c[s] = chan_q[s-1];
        stg_b[s] = byp_q[s-1];
        stg_v[s] = vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int s = 0; s < int'(M); s++) begin
        vld_q[s] <= 1'b0;
        for (int c = 0; c < int'(CH_SLOTS); c++) begin
          for (int k = 0; k < int'(N); k++) begin
            hist_q[s][c][k] <= '0;
          end
        end
        // Clear alone keeps data/tag registers so the output holds its last value.
        if (rst) begin
          data_q[s] <= '0;
          chan_q[s] <= '0;
          byp_q[s]  <= 1'b0;
        end
      end
    end else begin
      for (int s = 0; s < int'(M); s++) begin
        vld_q[s] <= stg_v[s];
        if (stg_v[s]) begin
          data_q[s] <= stg_b[s] ? stg_x[s]
                                : BITS'(stg_x[s] - hist_q[s][stg_c[s]][N-1]);
          chan_q[s] <= stg_c[s];
          byp_q[s]  <= stg_b[s];
          for (int k = 1; k < int'(N); k++) begin
            hist_q[s][stg_c[s]][k] <= hist_q[s][stg_c[s]][k-1];
          end
          hist_q[s][stg_c[s]][0] <= stg_x[s];
        end
      end
    end
  end

  assign stream_out = data_q[M-1];
  assign chan_out   = chan_q[M-1];
  assign ready      = vld_q[M-1];

endmodule

// File: doc/comb_tdm.md
# comb_tdm

Multi-channel, time-division-multiplexed comb section for the CIC decimator. It implements M cascaded differentiators, each with differential delay N, y[n] = x[n] − x[n−N]. Each channel keeps its own delay history, so CH decimated channels can share one arithmetic path. It sits after the decimation stage, replacing per-channel comb instances. It adds a per-sample bypass mode, a synchronous history clear and channel tagging.

## Interface
Parameters:
- M, 1, number of cascaded differentiator stages (≥1)
- N, 2, differential delay per stage in samples of the same channel (≥1)
- BITS, 10, two's-complement data width, input and output
- CH, 4, number of interleaved channels (≥1)
- CHW, $clog2(CH) (min 1), channel tag width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- stream_in  in  BITS  input sample, signed
- chan_in  in  CHW  channel of stream_in
- valid  in  1  stream_in/chan_in/bypass qualified this cycle
- bypass  in  1  sampled with valid; sample passes through unmodified
- clear  in  1  synchronous wipe of all channel histories
- stream_out  out  BITS  output sample, signed
- chan_out  out  CHW  channel of stream_out
- ready  out  1  stream_out/chan_out qualified this cycle (single-cycle pulse per sample)

## Operation
- Per stage s (0..M−1), per channel c: history hist[s][c][0..N−1] of BITS-bit registers, plus one pipeline register (data, chan, bypass, valid).
- Stage s with valid sample x on channel c: out = x − hist[s][c][N−1], computed modulo 2^BITS (wrap, no saturation, no growth). Then shift: hist[s][c][k] ← hist[s][c][k−1], hist[s][c][0] ← x.
- Bypass samples: out = x. History still updates exactly as above, so leaving bypass yields correct differences immediately.
- Only the addressed channel's history changes. Other channels are untouched.
- Cycles without valid: no history change, ready deasserted, stream_out/chan_out hold last value.
- chan_in ≥ CH (only possible when CH is not a power of two): sample dropped, no history update, no ready pulse for it.
- No backpressure. Downstream must accept one sample per cycle. Back-to-back valid on any channel mix is supported at full rate.
- clear: all hist registers ← 0 and all in-flight pipeline valids ← 0 in the same edge. A sample presented with valid in the clear cycle is dropped. Output data/chan registers hold their values.
- rst: identical to clear, and additionally zeros stream_out and chan_out.
- rst and clear together: rst behaviour.

## Timing
- Reset values: stream_out = 0, chan_out = 0, ready = 0, all histories 0.
- Latency: exactly M cycles from a valid input edge to the corresponding ready pulse (one register per stage).
- Throughput: 1 sample/cycle. Output order equals input order.
- Histories are updated at the same edge the stage's pipeline register captures the sample. A same-channel sample one cycle later therefore sees the updated history.
- Clear/reset mid-stream: no ready pulse for any sample accepted before the clear edge. The first post-clear sample on each channel differences against 0.
- Delay N counts samples of the same channel, not clock cycles. Gaps between a channel's samples are irrelevant.

## Test plan
- Reset: hold rst 3 cycles while driving valid=1, stream_in=100 → stream_out=0, chan_out=0, ready=0 throughout, and ready stays 0 one cycle after release.
- Step, M=1 N=2 CH=1: inputs 5,5,5,5 back-to-back → outputs 5,5,0,0, each ready exactly 1 cycle after its input. With M=2: outputs 5,5,−5,−5,0 on a 5,5,5,5,5 step, latency 2.
- Interleave, M=1 N=1 CH=2: (ch0,10),(ch1,3),(ch0,12),(ch1,7) → 10,3,2,4 with chan_out 0,1,0,1. Insert idle cycles between them → identical values.
- Wrap, M=1 N=1 BITS=10: inputs 511 then −512 → outputs 511 then 1 (−1023 mod 1024).
- Bypass/clear, M=1 N=1: inputs 20, 30 (bypass=1), 35 → 20,30,5. Then clear, then input 8 → output 8. A valid sample in the clear cycle produces no ready.
- Invalid channel, CH=3: (ch3,50) between (ch0,4) and (ch0,9) → only two ready pulses, values 4 and 5.
